debug_serial_tx: RTL and testbench
==================================

Name: debug_serial_tx

Overview:
- Downstream consumer of the cpu core's seven 8-bit debug ports.
- Snapshots all seven bytes in a single cycle and transmits them as one framed UART 8N1 packet to the host-side serial debugger.
- Framing: sync byte first, then port1..port7, then an optional checksum byte.
- Lives in the FPGA top level beside cpu and drives the board's TX pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, all state on posedge
- resetn  input  1  asynchronous active-low reset
- snap_valid  input  1  request to capture the debug bytes this cycle
- snap_ready  output  1  high when a capture is accepted this cycle (idle)
- port1 .. port7  input  8 each  debug bytes from cpu (debug_port1..debug_port7)
- tx  output  1  UART serial out, idle high
- busy  output  1  high while a frame is in flight
- frames_sent  output  16  count of completed frames, wraps

Behaviour:
- Interface (already decided): one clock, clk; reset is resetn, asynchronous and active-low.
- Reset values (asynchronous on resetn low): tx=1, busy=0, snap_ready=1, frames_sent=0, state=IDLE, snapshot registers=0.
- Reset mid-frame: tx returns high immediately; the partial frame is discarded and never resumed.
- Handshake: capture occurs on the clk edge where snap_valid && snap_ready.
- snap_ready = (state==IDLE); it is combinational from state.
- On acceptance, port1..port7 are latched into an internal 7-byte snapshot. Later port changes do not affect the frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept: byte_idx=0, baud counter=0, tx registered low from that edge. The start bit therefore appears in the cycle after acceptance.
  - START -> DATA after CLKS_PER_BIT cycles; bit_idx=0.
  - DATA: shifts the current byte LSB first, one bit per CLKS_PER_BIT cycles. After bit 7 completes -> STOP with tx=1.
  - STOP: holds tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx < LAST: byte_idx++ and -> START. No idle gap between bytes.
    - If byte_idx == LAST: -> IDLE and frames_sent++ on the same edge.
- Byte sequence: idx0=SYNC_BYTE, idx1..7=port1..port7, idx8=checksum (feature only). LAST=7, or 8 with the feature.
- busy = (state != IDLE). It is high from the cycle after acceptance through the final stop bit.
- Back-to-back frames: snap_valid held high is accepted in the first IDLE cycle. That gives exactly one cycle of tx=1 idle beyond the stop bit between frames.
- snap_valid while busy is ignored; no queuing.
- Frame length: (LAST+1)*10*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is sized by $clog2(CLKS_PER_BIT).
- frames_sent wraps 16'hFFFF -> 16'h0000.

Optional Feature:
- Macro: DEBUG_TX_CHECKSUM_EN.
- Defined:
  - A ninth byte is appended: the XOR of port1..port7 from the snapshot. SYNC_BYTE is excluded.
  - It is computed from the snapshot registers, not the live ports.
  - LAST=8; frame length is 90*CLKS_PER_BIT cycles.
- Undefined:
  - No checksum logic is present.
  - LAST=7; frame length is 80*CLKS_PER_BIT cycles.

Test Plan:
1. Reset: hold resetn=0 with snap_valid=1 -> tx=1, busy=0, snap_ready=1, frames_sent=0 throughout.
2. Single frame, CLKS_PER_BIT=4, ports=8'h01..8'h07, one-cycle snap_valid:
   - tx goes low the next cycle.
   - Decoded bytes are A5,01,02,03,04,05,06,07, LSB first, each bit 4 cycles wide.
   - busy lasts 320 cycles; frames_sent=1.
   - With the feature, a 9th byte 8'h00 follows (XOR of 01..07 = 00) and busy lasts 360 cycles.
3. Snapshot isolation: change port3 to 8'hFF one cycle after acceptance -> byte idx3 still transmits 8'h03.
4. Busy ignore: pulse snap_valid mid-frame -> snap_ready=0, no second frame; frames_sent increments by exactly 1.
5. Back-to-back, CLKS_PER_BIT=4: hold snap_valid=1 for three frames -> exactly one idle-high cycle between frames; frames_sent=3.
6. Reset mid-frame: assert resetn=0 during the DATA state of byte idx4 -> tx=1 asynchronously and frames_sent=0. After release, a new capture transmits a complete frame starting with A5.

Source files
------------

// File: rtl/debug_serial_tx.sv
// debug_serial_tx: snapshots seven cpu debug bytes and sends them as one
// UART 8N1 frame: SYNC_BYTE, port1..port7, and an optional checksum byte.
// Optional feature macro: DEBUG_TX_CHECKSUM_EN appends the XOR of port1..port7
// (taken from the snapshot) as a ninth byte.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | line idle high, snap_ready=1, waiting for snap_valid
// START   | driving start bit (low) for the current byte
// DATA    | shifting current byte out LSB first
// STOP    | driving stop bit (high); then next byte or back to IDLE

module debug_serial_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        snap_valid,
  output logic        snap_ready,
  input  logic [7:0]  port1,
  input  logic [7:0]  port2,
  input  logic [7:0]  port3,
  input  logic [7:0]  port4,
  input  logic [7:0]  port5,
  input  logic [7:0]  port6,
  input  logic [7:0]  port7,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

`ifdef DEBUG_TX_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [6:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [15:0]   frames_q, frames_d;
  logic [55:0]   snap_q, snap_d;
  logic [7:0]    cur_byte;
  logic          baud_end;

`ifdef DEBUG_TX_CHECKSUM_EN
  logic [7:0] csum;

  // Checksum over the captured bytes only, so live port changes cannot leak in.
  always_comb begin
    csum = snap_q[7:0] ^ snap_q[15:8] ^ snap_q[23:16] ^ snap_q[31:24]
         ^ snap_q[39:32] ^ snap_q[47:40] ^ snap_q[55:48];
  end
`endif

  assign baud_end    = (baud_q == BAUD_MAX);
  assign snap_ready  = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx          = tx_q;
  assign frames_sent = frames_q;

  // Select the byte currently being framed.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx_q)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = snap_q[7:0];
      4'd2:    cur_byte = snap_q[15:8];
      4'd3:    cur_byte = snap_q[23:16];
      4'd4:    cur_byte = snap_q[31:24];
      4'd5:    cur_byte = snap_q[39:32];
      4'd6:    cur_byte = snap_q[47:40];
      4'd7:    cur_byte = snap_q[55:48];
`ifdef DEBUG_TX_CHECKSUM_EN
      4'd8:    cur_byte = csum;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  // Next-state logic for the framing FSM, baud timer and bit shifter.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    frames_d   = frames_q;
    snap_d     = snap_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (snap_valid) begin
          snap_d     = {port7, port6, port5, port4, port3, port2, port1};
          state_d    = S_START;
          byte_idx_d = 4'd0;
          baud_d     = '0;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          shift_d   = cur_byte[7:1];
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[6:1]};
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_idx_q == LAST_IDX) begin
            state_d  = S_IDLE;
            frames_d = frames_q + 16'd1;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset forces the line high and drops any partial frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      shift_q    <= 7'd0;
      tx_q       <= 1'b1;
      frames_q   <= 16'd0;
      snap_q     <= 56'd0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      frames_q   <= frames_d;
      snap_q     <= snap_d;
    end
  end

endmodule

// File: tb/tb_debug_serial_tx.sv
// Directed bench for debug_serial_tx with CLKS_PER_BIT=4.
module tb_debug_serial_tx;

  localparam int CPB = 4;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FL = NB * 40;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        snap_valid = 1'b0;
  logic        snap_ready;
  logic [7:0]  port1, port2, port3, port4, port5, port6, port7;
  logic        tx, busy;
  logic [15:0] frames_sent;

  logic        tx_s   [0:2047];
  logic        busy_s [0:2047];
  logic [7:0]  exp_b  [0:8];

  int n_tests = 0;
  int n_fail  = 0;

  debug_serial_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .resetn(resetn), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .port1(port1), .port2(port2), .port3(port3), .port4(port4),
    .port5(port5), .port6(port6), .port7(port7),
    .tx(tx), .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ports(input logic [7:0] a, b, c, d, e, f, g, cks);
    port1 = a; port2 = b; port3 = c; port4 = d;
    port5 = e; port6 = f; port7 = g;
    exp_b[0] = 8'hA5;
    exp_b[1] = a; exp_b[2] = b; exp_b[3] = c; exp_b[4] = d;
    exp_b[5] = e; exp_b[6] = f; exp_b[7] = g; exp_b[8] = cks;
  endtask

  task automatic accept();
    @(negedge clk);
    check("snap_ready_idle", 32'(snap_ready), 32'd1);
    snap_valid = 1'b1;
    @(posedge clk);
    #1 snap_valid = 1'b0;
  endtask

  // Sample tx/busy at the negedge of each cycle following the accept edge.
  task automatic capture(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tx_s[c]   = tx;
      busy_s[c] = busy;
    end
  endtask

  // Decode bytes mid-bit and compare every sample against the ideal waveform.
  task automatic check_frame(input int base, input string tag);
    logic [7:0] b;
    int errs;
    logic want;
    int sym;
    for (int i = 0; i < NB; i++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) b[j] = tx_s[base + 40*i + 4*(1+j) + 1];
      check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_b[i]));
    end
    errs = 0;
    for (int c = 0; c < FL; c++) begin
      sym = (c % 40) / 4;
      if (sym == 0)      want = 1'b0;
      else if (sym == 9) want = 1'b1;
      else               want = exp_b[c / 40][sym - 1];
      if (tx_s[base + c] !== want) errs++;
    end
    check($sformatf("%s_wave", tag), 32'(errs), 32'd0);
  endtask

  function automatic int busy_count(input int base, input int n);
    int cnt = 0;
    for (int c = 0; c < n; c++) if (busy_s[base + c] === 1'b1) cnt++;
    return cnt;
  endfunction

  int lows;

  initial begin
    set_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00);

    // Reset held with snap_valid asserted.
    snap_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(snap_ready), 32'd1);
      check("rst_frames", 32'(frames_sent), 32'd0);
    end
    snap_valid = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame.
    accept();
    capture(FL + 2);
    check("single_start_next", 32'(tx_s[0]), 32'd0);
    check_frame(0, "single");
    check("single_busy_len", 32'(busy_count(0, FL + 2)), 32'(FL));
    check("single_busy_end", 32'(busy_s[FL]), 32'd0);
    check("single_idle_tx", 32'(tx_s[FL]), 32'd1);
    check("single_frames", 32'(frames_sent), 32'd1);

    // Snapshot isolation: port3 changes the cycle after acceptance.
    accept();
    port3 = 8'hFF;
    capture(FL + 2);
    check_frame(0, "iso");
    check("iso_frames", 32'(frames_sent), 32'd2);
    port3 = 8'h03;

    // snap_valid pulsed mid-frame is ignored.
    accept();
    fork
      capture(FL + 2);
      begin
        repeat (100) @(negedge clk);
        check("ign_ready_busy", 32'(snap_ready), 32'd0);
        snap_valid = 1'b1;
        @(negedge clk);
        snap_valid = 1'b0;
      end
    join
    check_frame(0, "ign");
    lows = 0;
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("ign_no_second", 32'(lows), 32'd0);
    check("ign_frames", 32'(frames_sent), 32'd3);

    // Back-to-back frames with snap_valid held high.
    set_ports(8'h80, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h11, 8'hCB);
    @(negedge clk);
    snap_valid = 1'b1;
    @(posedge clk);
    capture(3*FL + 3);
    snap_valid = 1'b0;
    check_frame(0, "b2b0");
    check_frame(FL + 1, "b2b1");
    check_frame(2*FL + 2, "b2b2");
    check("b2b_gap_tx", 32'(tx_s[FL]), 32'd1);
    check("b2b_gap_busy", 32'(busy_s[FL]), 32'd0);
    check("b2b_gap_start", 32'(tx_s[FL + 1]), 32'd0);
    check("b2b_gap2_tx", 32'(tx_s[2*FL + 1]), 32'd1);
    check("b2b_gap2_start", 32'(tx_s[2*FL + 2]), 32'd0);
    check("b2b_busy_len", 32'(busy_count(0, 3*FL + 3)), 32'(3*FL));
    repeat (5) @(negedge clk);
    check("b2b_stopped", 32'(busy), 32'd0);
    check("b2b_frames", 32'(frames_sent), 32'd6);

    // Reset during byte idx4 data bit 0 (tx low there).
    set_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00);
    accept();
    capture(166);
    check("mid_tx_low", 32'(tx_s[165]), 32'd0);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frames", 32'(frames_sent), 32'd0);
    check("mid_rst_ready", 32'(snap_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("mid_rst_hold_tx", 32'(tx), 32'd1);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_no_resume", 32'(busy), 32'd0);
    accept();
    capture(FL + 2);
    check_frame(0, "post_rst");
    check("post_rst_frames", 32'(frames_sent), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
